qar_mem_arbiter: RTL and testbench
==================================

Name: qar_mem_arbiter

Overview:
- Shares one single-port memory between the QAR-Core instruction-fetch port and its data port.
- Arbitrates between the two valid/ready requesters and forwards one transaction at a time downstream.
- Routes the response back to the requester that was granted.
- Adds starvation protection for fetch and a downstream timeout that returns a bus error.
- Sits between qar_core (USE_INTERNAL_IMEM=0, USE_INTERNAL_DMEM=0) and a unified RAM/peripheral fabric.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced to win (1..255).
- TIMEOUT_CYCLES, 64, cycles in BUS without m_ready before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  fetch request
- i_addr  in  ADDR_WIDTH  fetch address
- i_ready  out  1  one-cycle fetch completion pulse
- i_rdata  out  DATA_WIDTH  fetch data, valid while i_ready=1
- i_err  out  1  fetch timed out, qualified by i_ready
- d_valid  in  1  data request
- d_we  in  1  data write enable
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_ready  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_WIDTH  load data, valid while d_ready=1
- d_err  out  1  data timed out, qualified by d_ready
- m_valid  out  1  downstream request
- m_we  out  1  downstream write enable
- m_addr  out  ADDR_WIDTH  downstream address
- m_wdata  out  DATA_WIDTH  downstream write data
- m_ready  in  1  downstream completion, sampled while m_valid=1
- m_rdata  in  DATA_WIDTH  downstream read data, valid with m_ready
- grant_d  out  1  1 while the current or last transaction belongs to the data port

Behaviour:
- Reset (asynchronous, immediate):
  - State=IDLE.
  - All outputs 0; counters 0.
  - m_valid drops in the same cycle rst rises. An in-flight transaction is abandoned with no response.
- All outputs are registered.
- State machine:
  - IDLE → BUS when i_valid or d_valid is sampled high.
  - BUS → RESP on m_ready, or on timeout.
  - RESP → IDLE unconditionally.
- IDLE:
  - Pick the winner.
  - Latch the winner's addr, we and wdata into m_*. Fetch always has we=0.
  - Set grant_d and assert m_valid at the next edge.
- Pick rule:
  - Only one valid → that port wins.
  - Both valid → data wins, unless starve_cnt >= STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - Increments (saturating) when data wins while i_valid=1.
  - Clears when fetch wins or when i_valid=0 in IDLE.
- BUS:
  - m_valid=1 and m_* stay stable; upstream changes are ignored.
  - tmo_cnt increments each cycle.
  - If m_ready=1: capture m_rdata (0 for writes), err=0, go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and tmo_cnt==TIMEOUT_CYCLES-1: err=1, rdata=0, go to RESP.
  - m_ready in the expiry cycle takes precedence; no error is reported.
- RESP:
  - m_valid=0.
  - The granted port's ready=1 for exactly one cycle, with rdata/err. The other port's ready=0.
  - tmo_cnt clears.
  - Next cycle is IDLE, which samples the requesters' post-handshake valids.
- Latency: request sampled at edge N → m_valid from N+1 → with m_ready at N+1, x_ready at N+2, next IDLE at N+3.
- Throughput: at most one transaction per 3 cycles.
- Idle outputs: i_rdata, d_rdata and err hold 0 when their ready=0.
- Protocol violations: a requester that drops valid before ready still receives the response pulse. The arbiter never cancels a downstream access.

Decomposition:
- Shared package qar_mem_arb_pkg holds:
  - state encoding ST_IDLE=2'd0, ST_BUS=2'd1, ST_RESP=2'd2;
  - grant IDs GNT_I=1'b0, GNT_D=1'b1;
  - ERR_RDATA=32'h0.
- One sub-module, qar_sat_counter (parameter WIDTH; inputs clk, rst, inc, clr; output cnt, saturating), instantiated twice: once for starve_cnt and once for tmo_cnt.

Test Plan:
- Lone fetch: i_valid=1, i_addr=0x10, m_ready same cycle as m_valid, m_rdata=0x00000013 → m_valid one cycle after the request, i_ready pulse two cycles after it, i_rdata=0x13, i_err=0, d_ready=0.
- Simultaneous: both valid, d_we=1, d_addr=0x104, d_wdata=0x100 → data granted first (m_we=1, m_addr=0x104, m_wdata=0x100), d_rdata=0, then fetch served next.
- Starvation: d_valid held high with i_valid high, STARVE_LIMIT=4 → exactly 4 data grants, then one fetch grant, then data resumes.
- Timeout: TIMEOUT_CYCLES=8, m_ready tied 0, d_valid read → m_valid high for exactly 8 cycles, then d_ready=1, d_err=1, d_rdata=0; m_ready=1 on the 8th cycle instead → d_err=0.
- Reset mid-BUS: assert rst while m_valid=1 → m_valid, i_ready, d_ready drop immediately; after release, a new fetch to 0x20 completes normally.
- Back-to-back loads: d_valid held with new addresses each handshake, m_ready always 1 → d_ready pulses every 3 cycles with matching data, no duplicate or lost pulses.

Source files
------------

// File: rtl/qar_mem_arb_pkg.sv
// Shared definitions for the QAR-Core memory arbiter: FSM encoding,
// grant identifiers and the data value returned with a bus error.
package qar_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic        GNT_I     = 1'b0;
    localparam logic        GNT_D     = 1'b1;
    localparam logic [31:0] ERR_RDATA = 32'h0;

    // Bits needed to hold max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/qar_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module qar_sat_counter
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    // Count up on inc, hold at all-ones, return to zero on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/qar_mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one single-port memory fabric.
// One transaction at a time: IDLE picks a winner, BUS holds the downstream
// request until m_ready or timeout, RESP pulses the winner's ready.
module qar_mem_arbiter
    import qar_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_err,
    input  logic                  d_valid,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  m_valid,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  grant_d
);

    localparam int STARVE_W = 8;
    localparam int TMO_W    = cnt_width(TIMEOUT_CYCLES);

    state_t                state, state_nxt;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  req_any;
    logic                  pick_d;
    logic                  tmo_hit;
    logic                  starve_inc, starve_clr;
    logic                  tmo_inc, tmo_clr;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    logic                  m_valid_nxt, m_we_nxt, grant_d_nxt;
    logic [ADDR_WIDTH-1:0] m_addr_nxt;
    logic [DATA_WIDTH-1:0] m_wdata_nxt;
    logic                  i_ready_nxt, i_err_nxt, d_ready_nxt, d_err_nxt;
    logic [DATA_WIDTH-1:0] i_rdata_nxt, d_rdata_nxt;

    assign req_any = i_valid | d_valid;

    // Winner selection: data is preferred unless fetch has waited too long.
    always_comb begin
        pick_d = GNT_I;
        if (d_valid && !i_valid) begin
            pick_d = GNT_D;
        end else if (d_valid && i_valid) begin
            pick_d = (starve_cnt >= STARVE_W'(STARVE_LIMIT)) ? GNT_I : GNT_D;
        end
    end

    // A disabled timeout (0 cycles) never fires.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Starvation tracks consecutive data wins over a waiting fetch.
    assign starve_inc = (state == ST_IDLE) && i_valid && (pick_d == GNT_D);
    assign starve_clr = (state == ST_IDLE) && (!i_valid || (pick_d == GNT_I));
    assign tmo_inc    = (state == ST_BUS);
    assign tmo_clr    = (state != ST_BUS);

    qar_sat_counter #(.WIDTH(STARVE_W)) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .cnt (starve_cnt)
    );

    qar_sat_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .inc (tmo_inc),
        .clr (tmo_clr),
        .cnt (tmo_cnt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; m_ready in the expiry cycle also ends BUS.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_any) state_nxt = ST_BUS;
            ST_BUS:  if (m_ready || tmo_hit) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response payload: read data on success, zero for writes and errors.
    assign rsp_err  = !m_ready;
    assign rsp_data = (m_ready && !m_we) ? m_rdata : DATA_WIDTH'(ERR_RDATA);

    // Next values of every registered output.
    always_comb begin
        m_valid_nxt = (state_nxt == ST_BUS);
        m_we_nxt    = m_we;
        m_addr_nxt  = m_addr;
        m_wdata_nxt = m_wdata;
        grant_d_nxt = grant_d;
        i_ready_nxt = 1'b0;
        i_rdata_nxt = '0;
        i_err_nxt   = 1'b0;
        d_ready_nxt = 1'b0;
        d_rdata_nxt = '0;
        d_err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    grant_d_nxt = pick_d;
                    if (pick_d == GNT_D) begin
                        m_we_nxt    = d_we;
                        m_addr_nxt  = d_addr;
                        m_wdata_nxt = d_wdata;
                    end else begin
                        m_we_nxt    = 1'b0;
                        m_addr_nxt  = i_addr;
                        m_wdata_nxt = '0;
                    end
                end
            end
            ST_BUS: begin
                if (state_nxt == ST_RESP) begin
                    if (grant_d == GNT_D) begin
                        d_ready_nxt = 1'b1;
                        d_rdata_nxt = rsp_data;
                        d_err_nxt   = rsp_err;
                    end else begin
                        i_ready_nxt = 1'b1;
                        i_rdata_nxt = rsp_data;
                        i_err_nxt   = rsp_err;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers; reset clears them immediately, abandoning any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            grant_d <= 1'b0;
            i_ready <= 1'b0;
            i_rdata <= '0;
            i_err   <= 1'b0;
            d_ready <= 1'b0;
            d_rdata <= '0;
            d_err   <= 1'b0;
        end else begin
            m_valid <= m_valid_nxt;
            m_we    <= m_we_nxt;
            m_addr  <= m_addr_nxt;
            m_wdata <= m_wdata_nxt;
            grant_d <= grant_d_nxt;
            i_ready <= i_ready_nxt;
            i_rdata <= i_rdata_nxt;
            i_err   <= i_err_nxt;
            d_ready <= d_ready_nxt;
            d_rdata <= d_rdata_nxt;
            d_err   <= d_err_nxt;
        end
    end

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Scoreboard bench for qar_mem_arbiter: expected grants and responses are
// queued when stimulus is applied and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_qar_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_ready, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_valid, d_we, d_ready, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_valid, m_we, m_ready, grant_d;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    qar_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic req_t mk_req(input logic p, input logic w,
                                    input logic [31:0] a, input logic [31:0] wd);
        req_t r;
        r.port = p; r.we = w; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    function automatic rsp_t mk_rsp(input logic p, input logic [31:0] rd, input logic e);
        rsp_t r;
        r.port = p; r.rdata = rd; r.err = e;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Downstream memory model: completes in the first m_valid cycle when enabled.
    task automatic respond(input bit en);
        if (m_valid && en) begin
            m_ready = 1'b1;
            m_rdata = m_we ? 32'hDEAD_BEEF : mem_fn(m_addr);
        end else begin
            m_ready = 1'b0;
            m_rdata = '0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_valid = 0; i_addr = '0; d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m_ready = 0; m_rdata = '0;
        step(); step();
        n_checks++;
        if ({m_valid, m_we, m_addr, m_wdata, grant_d} !== '0) begin
            n_errors++;
            $display("FAIL reset_m: m_valid=%0b m_we=%0b m_addr=%h m_wdata=%h grant_d=%0b, need all 0",
                     m_valid, m_we, m_addr, m_wdata, grant_d);
        end
        n_checks++;
        if ({i_ready, i_rdata, i_err, d_ready, d_rdata, d_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_resp: i_ready=%0b i_rdata=%h i_err=%0b d_ready=%0b d_rdata=%h d_err=%0b, need all 0",
                     i_ready, i_rdata, i_err, d_ready, d_rdata, d_err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lone_fetch();
        rsp_t e;
        rsp_q.push_back(mk_rsp(1'b0, 32'h0000_0013, 1'b0));
        i_valid = 1; i_addr = 32'h10;
        step();
        n_checks++;
        if (m_valid !== 1'b1 || m_addr !== 32'h10 || m_we !== 1'b0 || grant_d !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_req: m_valid=%0b m_addr=%h m_we=%0b grant_d=%0b, need 1/00000010/0/0",
                     m_valid, m_addr, m_we, grant_d);
        end
        m_ready = 1; m_rdata = 32'h0000_0013;
        step();
        e = rsp_q.pop_front();
        n_checks++;
        if (i_ready !== 1'b1 || i_rdata !== e.rdata || i_err !== e.err || d_ready !== 1'b0 || m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_resp: i_ready=%0b i_rdata=%h i_err=%0b d_ready=%0b m_valid=%0b, need 1/%h/%0b/0/0",
                     i_ready, i_rdata, i_err, d_ready, m_valid, e.rdata, e.err);
        end
        i_valid = 0; m_ready = 0; m_rdata = '0;
        step();
        n_checks++;
        if (i_ready !== 1'b0 || i_rdata !== '0 || i_err !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_idle: i_ready=%0b i_rdata=%h i_err=%0b, need 0/0/0", i_ready, i_rdata, i_err);
        end
        step();
    endtask

    task automatic test_simultaneous();
        bit   prev_mv;
        int   cyc;
        req_t eq;
        rsp_t er;
        req_q.push_back(mk_req(1'b1, 1'b1, 32'h104, 32'h100));
        req_q.push_back(mk_req(1'b0, 1'b0, 32'h30, 32'h0));
        rsp_q.push_back(mk_rsp(1'b1, 32'h0, 1'b0));
        rsp_q.push_back(mk_rsp(1'b0, mem_fn(32'h30), 1'b0));
        i_valid = 1; i_addr = 32'h30;
        d_valid = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'h100;
        prev_mv = 0; cyc = 0;
        while ((req_q.size() != 0 || rsp_q.size() != 0) && cyc < 30) begin
            step(); cyc++;
            if (m_valid && !prev_mv) begin
                n_checks++;
                if (req_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL simul_req: unexpected grant addr=%h", m_addr);
                end else begin
                    eq = req_q.pop_front();
                    if (grant_d !== eq.port || m_we !== eq.we || m_addr !== eq.addr ||
                        (eq.we && m_wdata !== eq.wdata)) begin
                        n_errors++;
                        $display("FAIL simul_req: grant_d=%0b we=%0b addr=%h wdata=%h, need %0b/%0b/%h/%h",
                                 grant_d, m_we, m_addr, m_wdata, eq.port, eq.we, eq.addr, eq.wdata);
                    end
                end
            end
            prev_mv = m_valid;
            respond(1);
            if (i_ready || d_ready) begin
                n_checks++;
                if (rsp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL simul_rsp: unexpected pulse i_ready=%0b d_ready=%0b", i_ready, d_ready);
                end else begin
                    er = rsp_q.pop_front();
                    if (d_ready !== er.port || i_ready !== !er.port ||
                        (er.port ? d_rdata : i_rdata) !== er.rdata || (er.port ? d_err : i_err) !== er.err) begin
                        n_errors++;
                        $display("FAIL simul_rsp: i_ready=%0b d_ready=%0b i_rdata=%h d_rdata=%h, need port %0b rdata %h err %0b",
                                 i_ready, d_ready, i_rdata, d_rdata, er.port, er.rdata, er.err);
                    end
                end
                if (d_ready) d_valid = 0;
                if (i_ready) i_valid = 0;
            end
        end
        n_checks++;
        if (req_q.size() != 0 || rsp_q.size() != 0) begin
            n_errors++;
            $display("FAIL simul_done: %0d grants and %0d responses outstanding, need 0", req_q.size(), rsp_q.size());
        end
        req_q.delete(); rsp_q.delete();
        d_we = 0; m_ready = 0;
        step();
    endtask

    task automatic test_starvation();
        bit   prev_mv;
        int   cyc, d_cnt;
        req_t eq;
        rsp_t er;
        for (int k = 0; k < 4; k++) begin
            req_q.push_back(mk_req(1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'h0));
            rsp_q.push_back(mk_rsp(1'b1, mem_fn(32'h200 + 32'(4 * k)), 1'b0));
        end
        req_q.push_back(mk_req(1'b0, 1'b0, 32'h40, 32'h0));
        rsp_q.push_back(mk_rsp(1'b0, mem_fn(32'h40), 1'b0));
        for (int k = 4; k < 6; k++) begin
            req_q.push_back(mk_req(1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'h0));
            rsp_q.push_back(mk_rsp(1'b1, mem_fn(32'h200 + 32'(4 * k)), 1'b0));
        end
        i_valid = 1; i_addr = 32'h40;
        d_valid = 1; d_we = 0; d_addr = 32'h200;
        prev_mv = 0; cyc = 0; d_cnt = 0;
        while ((req_q.size() != 0 || rsp_q.size() != 0) && cyc < 60) begin
            step(); cyc++;
            if (m_valid && !prev_mv) begin
                n_checks++;
                if (req_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL starve_req: unexpected grant addr=%h", m_addr);
                end else begin
                    eq = req_q.pop_front();
                    if (grant_d !== eq.port || m_we !== eq.we || m_addr !== eq.addr) begin
                        n_errors++;
                        $display("FAIL starve_req: grant_d=%0b we=%0b addr=%h, need %0b/%0b/%h",
                                 grant_d, m_we, m_addr, eq.port, eq.we, eq.addr);
                    end
                end
            end
            prev_mv = m_valid;
            respond(1);
            if (i_ready || d_ready) begin
                n_checks++;
                if (rsp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL starve_rsp: unexpected pulse i_ready=%0b d_ready=%0b", i_ready, d_ready);
                end else begin
                    er = rsp_q.pop_front();
                    if (d_ready !== er.port || i_ready !== !er.port ||
                        (er.port ? d_rdata : i_rdata) !== er.rdata || (er.port ? d_err : i_err) !== er.err) begin
                        n_errors++;
                        $display("FAIL starve_rsp: i_ready=%0b d_ready=%0b i_rdata=%h d_rdata=%h, need port %0b rdata %h",
                                 i_ready, d_ready, i_rdata, d_rdata, er.port, er.rdata);
                    end
                end
                if (i_ready) i_valid = 0;
                if (d_ready) begin
                    d_cnt++;
                    d_addr = 32'h200 + 32'(4 * d_cnt);
                    if (d_cnt == 6) d_valid = 0;
                end
            end
        end
        n_checks++;
        if (req_q.size() != 0 || rsp_q.size() != 0) begin
            n_errors++;
            $display("FAIL starve_done: %0d grants and %0d responses outstanding, need 0", req_q.size(), rsp_q.size());
        end
        req_q.delete(); rsp_q.delete();
        i_valid = 0; d_valid = 0; m_ready = 0;
        step();
    endtask

    task automatic test_timeout(input bit late_ready);
        int   cyc, mv;
        bit   got;
        rsp_t er;
        rsp_q.push_back(mk_rsp(1'b1, late_ready ? 32'h0000_1234 : 32'h0, !late_ready));
        d_valid = 1; d_we = 0; d_addr = 32'h500; m_ready = 0; m_rdata = '0;
        cyc = 0; mv = 0; got = 0;
        while (!got && cyc < 30) begin
            step(); cyc++;
            if (m_valid) begin
                mv++;
                if (late_ready && mv == TC) begin
                    m_ready = 1; m_rdata = 32'h0000_1234;
                end else begin
                    m_ready = 0; m_rdata = '0;
                end
            end else begin
                m_ready = 0; m_rdata = '0;
            end
            if (d_ready) begin
                got = 1;
                d_valid = 0;
                er = rsp_q.pop_front();
                n_checks++;
                if (d_err !== er.err || d_rdata !== er.rdata || i_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL timeout_rsp(late=%0b): d_err=%0b d_rdata=%h i_ready=%0b, need %0b/%h/0",
                             late_ready, d_err, d_rdata, i_ready, er.err, er.rdata);
                end
            end
        end
        n_checks++;
        if (!got || mv != TC) begin
            n_errors++;
            $display("FAIL timeout_len(late=%0b): response=%0b m_valid cycles=%0d, need 1/%0d", late_ready, got, mv, TC);
        end
        rsp_q.delete();
        d_valid = 0; m_ready = 0;
        step();
    endtask

    task automatic test_reset_mid_bus();
        req_t eq;
        rsp_t er;
        i_valid = 1; i_addr = 32'h60; m_ready = 0;
        step();
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rstbus_pre: m_valid=%0b, need 1", m_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rstbus_drop: m_valid=%0b i_ready=%0b d_ready=%0b, need 0/0/0", m_valid, i_ready, d_ready);
        end
        i_valid = 0;
        step(); step();
        rst = 1'b0;
        step();
        n_checks++;
        if (m_valid !== 1'b0 || i_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rstbus_abandon: m_valid=%0b i_ready=%0b, need 0/0", m_valid, i_ready);
        end
        req_q.push_back(mk_req(1'b0, 1'b0, 32'h20, 32'h0));
        rsp_q.push_back(mk_rsp(1'b0, mem_fn(32'h20), 1'b0));
        i_valid = 1; i_addr = 32'h20;
        step();
        eq = req_q.pop_front();
        n_checks++;
        if (m_valid !== 1'b1 || grant_d !== eq.port || m_addr !== eq.addr || m_we !== eq.we) begin
            n_errors++;
            $display("FAIL rstbus_req: m_valid=%0b grant_d=%0b m_addr=%h m_we=%0b, need 1/%0b/%h/%0b",
                     m_valid, grant_d, m_addr, m_we, eq.port, eq.addr, eq.we);
        end
        respond(1);
        step();
        er = rsp_q.pop_front();
        n_checks++;
        if (i_ready !== 1'b1 || i_rdata !== er.rdata || i_err !== er.err || d_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rstbus_rsp: i_ready=%0b i_rdata=%h i_err=%0b d_ready=%0b, need 1/%h/%0b/0",
                     i_ready, i_rdata, i_err, d_ready, er.rdata, er.err);
        end
        i_valid = 0; m_ready = 0;
        step();
    endtask

    task automatic test_back_to_back();
        int   cyc, d_cnt, last_cyc;
        rsp_t er;
        for (int k = 0; k < 5; k++)
            rsp_q.push_back(mk_rsp(1'b1, mem_fn(32'h300 + 32'(4 * k)), 1'b0));
        d_valid = 1; d_we = 0; d_addr = 32'h300;
        cyc = 0; d_cnt = 0; last_cyc = 0;
        while (cyc < 25) begin
            step(); cyc++;
            respond(1);
            if (i_ready || d_ready) begin
                n_checks++;
                if (rsp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL b2b_rsp: extra pulse i_ready=%0b d_ready=%0b at cycle %0d", i_ready, d_ready, cyc);
                end else begin
                    er = rsp_q.pop_front();
                    if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== er.rdata || d_err !== er.err) begin
                        n_errors++;
                        $display("FAIL b2b_rsp: d_ready=%0b i_ready=%0b d_rdata=%h d_err=%0b, need 1/0/%h/0",
                                 d_ready, i_ready, d_rdata, d_err, er.rdata);
                    end
                end
                if (d_cnt > 0) begin
                    n_checks++;
                    if (cyc - last_cyc != 3) begin
                        n_errors++;
                        $display("FAIL b2b_gap: pulse spacing %0d cycles, need 3", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                d_cnt++;
                d_addr = 32'h300 + 32'(4 * d_cnt);
                if (d_cnt == 5) d_valid = 0;
            end
        end
        n_checks++;
        if (d_cnt != 5) begin
            n_errors++;
            $display("FAIL b2b_count: %0d pulses, need 5", d_cnt);
        end
        rsp_q.delete();
        d_valid = 0; m_ready = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_bus();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule
